physical_rx_eye_scan: RTL and testbench
=======================================

// Module: physical_rx_eye_scan
// PURPOSE
//  Per-lane IDELAY tap calibration for the receiver physical layer. It sweeps every
//  delay tap and checks ISERDES word stability during training at each tap. It then
//  selects the centre of the widest stable window per lane and drives the result to
//  the IDELAYE2 CNTVALUEIN (VAR_LOAD). It sits in the clk_200 domain beside the
//  iob/iserdes stage and replaces fixed i_delay_val settings with LANES-wide auto-calibration.
// PARAMETERS
//  LANES          1   number of independent receive lanes
//  DATA_W         6   ISERDES word width per lane
//  TAP_W          5   delay tap width; N_TAPS = 2**TAP_W
//  SETTLE_CYCLES 16   cycles waited after a tap change before sampling (>=1)
//  SAMPLE_CYCLES 64   words checked per tap (>=2)
//  MIN_EYE        4   minimum window width (taps) for lock (1..N_TAPS)
// PORTS
//  i_clk        in   1               clk_200; the only clock
//  i_rst        in   1               synchronous reset, active-high
//  i_start      in   1               start a scan (acted on only in IDLE)
//  i_data       in   LANES*DATA_W    ISERDES words; lane n = [n*DATA_W +: DATA_W]
//  o_delay_val  out  LANES*TAP_W     tap value per lane, to IDELAYE2 CNTVALUEIN
//  o_eye_width  out  LANES*(TAP_W+1) widest stable window per lane, in taps
//  o_lock       out  LANES           lane window width >= MIN_EYE
//  o_busy       out  1               scan in progress
//  o_done       out  1               one-cycle pulse, scan finished
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, tap=0, all per-lane run registers 0.
//  All outputs are registered.
//  i_rst wins over every other input. Reset during a scan aborts it and clears all results.
//  FSM: IDLE -> SETTLE -> SAMPLE -> EVAL -> (SETTLE | FINISH) -> IDLE.
//   IDLE:   i_start=1 -> SETTLE, tap=0, clear per-lane run/best registers,
//           o_busy=1 from the next cycle; i_start while busy is ignored (not queued).
//   SETTLE: count SETTLE_CYCLES cycles, then -> SAMPLE.
//   SAMPLE: SAMPLE_CYCLES cycles. Per lane, capture the first word, then compare every
//           later word with it; any mismatch clears lane good flag.
//   EVAL:   1 cycle; per-lane good = all words equal AND word not all-0/all-1.
//           good: cur_len++ (cur_start=tap when cur_len was 0);
//                 if new cur_len > best_len then best_start=cur_start, best_len=cur_len.
//           bad:  cur_len=0. Ties keep the earlier (lower-tap) window (strict >).
//           tap==N_TAPS-1 -> FINISH, else tap++ -> SETTLE.
//           A run reaching the last tap closes at the sweep end; taps do not wrap.
//   FINISH: 1 cycle; per lane: o_eye_width=best_len, o_lock=(best_len>=MIN_EYE),
//           o_delay_val = lock ? best_start + (best_len>>1) : 0 (fits TAP_W, no overflow).
//           Next cycle: IDLE, o_busy=0, o_done=1 for exactly that cycle. i_start in the
//           o_done cycle is accepted.
//  During SETTLE/SAMPLE/EVAL every lane's o_delay_val = current sweep tap.
//  o_eye_width/o_lock hold their previous results until FINISH.
//  Latency: i_start sampled in cycle 0 -> o_done in cycle N_TAPS*(SETTLE_CYCLES+SAMPLE_CYCLES+1)+2.
//  Width rules: cur/best_len TAP_W+1 bits (holds N_TAPS); counters sized by $clog2 of params.
//  Lanes are evaluated in parallel and independently; one lane's result never affects another.
// TESTING  (TAP_W=5, SETTLE_CYCLES=2, SAMPLE_CYCLES=4, MIN_EYE=4; bench models data vs tap)
//  1 all taps stable 6'b101010 -> width 32, delay 16, lock 1; o_done at cycle 32*7+2=226.
//  2 stable only at taps 10..20, toggling elsewhere -> width 11, delay 15, lock 1.
//  3 windows 3..6 and 20..23 (equal len 4) -> earliest kept: width 4, delay 5, lock 1.
//  4 always toggling or all-zero data -> width 0, delay 0, lock 0; o_done still pulses.
//  5 LANES=2: lane0 good 0..7, lane1 good 25..31 -> delays 4/28, widths 8/7, locks 1/1.
//  6 i_start during busy ignored; i_rst at tap 12 -> outputs 0, IDLE; rescan runs normally.

Source files
------------

// File: rtl/physical_rx_eye_scan_if.sv
// physical_rx_eye_scan_if: start/data in, per-lane tap results out for the eye-scan calibrator
interface physical_rx_eye_scan_if #(
  parameter int LANES  = 1,
  parameter int DATA_W = 6,
  parameter int TAP_W  = 5
);
  logic                       i_start;
  logic [LANES*DATA_W-1:0]    i_data;
  logic [LANES*TAP_W-1:0]     o_delay_val;
  logic [LANES*(TAP_W+1)-1:0] o_eye_width;
  logic [LANES-1:0]           o_lock;
  logic                       o_busy;
  logic                       o_done;
  modport master (
    output i_start, i_data,
    input  o_delay_val, o_eye_width, o_lock, o_busy, o_done
  );
  modport slave (
    input  i_start, i_data,
    output o_delay_val, o_eye_width, o_lock, o_busy, o_done
  );
endinterface

// File: rtl/physical_rx_eye_scan.sv
// physical_rx_eye_scan: sweeps IDELAY taps, finds the widest stable ISERDES window per lane, drives its centre
module physical_rx_eye_scan #(
  parameter int LANES         = 1,
  parameter int DATA_W        = 6,
  parameter int TAP_W         = 5,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 64,
  parameter int MIN_EYE       = 4
) (
  input logic i_clk,
  input logic i_rst,
  physical_rx_eye_scan_if.slave bus
);
  localparam int MAXC = SETTLE_CYCLES > SAMPLE_CYCLES ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] P_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [TAP_W:0] MIN_L = (TAP_W+1)'(MIN_EYE);
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, EVAL, FINISH} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [TAP_W-1:0] tap, tap_nxt;
  logic last_cnt, sweep_nxt;
  logic [DATA_W-1:0] ref_w [LANES];
  logic              good [LANES];
  logic              ok [LANES];
  logic [TAP_W:0]    cur_len [LANES];
  logic [TAP_W:0]    best_len [LANES];
  logic [TAP_W:0]    nlen [LANES];
  logic [TAP_W-1:0]  cur_start [LANES];
  logic [TAP_W-1:0]  best_start [LANES];
  logic [TAP_W-1:0]  nstart [LANES];
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    last_cnt = state == SETTLE ? cnt == S_LAST : cnt == P_LAST;
    nxt = state == IDLE   ? (bus.i_start ? SETTLE : IDLE) :
          state == SETTLE ? (last_cnt ? SAMPLE : SETTLE) :
          state == SAMPLE ? (last_cnt ? EVAL : SAMPLE) :
          state == EVAL   ? (&tap ? FINISH : SETTLE) : IDLE;
    tap_nxt = state == IDLE ? '0 : (state == EVAL && !(&tap)) ? tap + 1'b1 : tap;
    sweep_nxt = nxt == SETTLE || nxt == SAMPLE || nxt == EVAL;
    for (int n = 0; n < LANES; n++) begin
      ok[n] = good[n] && ref_w[n] != '0 && ref_w[n] != '1;
      nlen[n] = cur_len[n] + 1'b1;
      nstart[n] = cur_len[n] == '0 ? tap : cur_start[n];
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tap <= '0;
      cnt <= '0;
      bus.o_delay_val <= '0;
      bus.o_eye_width <= '0;
      bus.o_lock <= '0;
      bus.o_busy <= 1'b0;
      bus.o_done <= 1'b0;
      for (int n = 0; n < LANES; n++) begin
        ref_w[n] <= '0;
        good[n] <= 1'b0;
        cur_len[n] <= '0;
        best_len[n] <= '0;
        cur_start[n] <= '0;
        best_start[n] <= '0;
      end
    end else begin
      tap <= tap_nxt;
      cnt <= nxt != state ? '0 : cnt + 1'b1;
      bus.o_busy <= nxt != IDLE;
      bus.o_done <= state == FINISH;
      for (int n = 0; n < LANES; n++) begin
        if (state == IDLE && bus.i_start) begin
          cur_len[n] <= '0;
          best_len[n] <= '0;
          cur_start[n] <= '0;
          best_start[n] <= '0;
        end
        // first word of the tap becomes the reference; any later difference marks the tap unstable
        if (state == SAMPLE && cnt == '0) begin
          ref_w[n] <= bus.i_data[n*DATA_W +: DATA_W];
          good[n] <= 1'b1;
        end else if (state == SAMPLE && bus.i_data[n*DATA_W +: DATA_W] != ref_w[n])
          good[n] <= 1'b0;
        if (state == EVAL && ok[n]) begin
          cur_len[n] <= nlen[n];
          cur_start[n] <= nstart[n];
          if (nlen[n] > best_len[n]) begin
            best_len[n] <= nlen[n];
            best_start[n] <= nstart[n];
          end
        end else if (state == EVAL)
          cur_len[n] <= '0;
        if (state == FINISH) begin
          bus.o_eye_width[n*(TAP_W+1) +: TAP_W+1] <= best_len[n];
          bus.o_lock[n] <= best_len[n] >= MIN_L;
          bus.o_delay_val[n*TAP_W +: TAP_W] <= best_len[n] >= MIN_L ? best_start[n] + best_len[n][TAP_W:1] : '0;
        end else if (sweep_nxt)
          bus.o_delay_val[n*TAP_W +: TAP_W] <= tap_nxt;
      end
    end
  end
endmodule

// File: tb/tb_physical_rx_eye_scan.sv
// tb_physical_rx_eye_scan: directed tap-window patterns on two lanes with hand-computed eye results
module tb_physical_rx_eye_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc;
  logic [31:0] mask [2];
  logic [5:0]  word [2];
  logic tgl = 1'b0;
  always #5 clk = ~clk;
  physical_rx_eye_scan_if #(.LANES(2), .DATA_W(6), .TAP_W(5)) bus();
  physical_rx_eye_scan #(
    .LANES(2), .DATA_W(6), .TAP_W(5),
    .SETTLE_CYCLES(2), .SAMPLE_CYCLES(4), .MIN_EYE(4)
  ) u_dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always @(negedge clk) begin
    logic [4:0] tp;
    logic [11:0] d;
    tgl = ~tgl;
    for (int n = 0; n < 2; n++) begin
      tp = bus.o_delay_val[n*5 +: 5];
      d[n*6 +: 6] = mask[n][tp] ? word[n] : (tgl ? 6'b000111 : 6'b111000);
    end
    bus.i_data = d;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic set_pat(input logic [31:0] m0, input logic [5:0] w0, input logic [31:0] m1, input logic [5:0] w1);
    mask[0] = m0; word[0] = w0; mask[1] = m1; word[1] = w1;
  endtask
  task automatic run_scan(input string tag, output int c);
    @(negedge clk) bus.i_start = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    c = 1;
    chk({tag, "_busy1"}, bus.o_busy, 1);
    chk({tag, "_tap0"}, bus.o_delay_val[4:0], 0);
    while (!bus.o_done && c < 1000) begin
      @(posedge clk);
      #1 c++;
    end
    chk({tag, "_done"}, bus.o_done, 1);
    chk({tag, "_busy0"}, bus.o_busy, 0);
  endtask
  task automatic res(input string tag, input int d0, input int w0, input int k0, input int d1, input int w1, input int k1);
    chk({tag, "_d0"}, bus.o_delay_val[4:0], d0);
    chk({tag, "_w0"}, bus.o_eye_width[5:0], w0);
    chk({tag, "_k0"}, bus.o_lock[0], k0);
    chk({tag, "_d1"}, bus.o_delay_val[9:5], d1);
    chk({tag, "_w1"}, bus.o_eye_width[11:6], w1);
    chk({tag, "_k1"}, bus.o_lock[1], k1);
  endtask
  initial begin
    int k;
    bus.i_start = 1'b0;
    set_pat(32'hffffffff, 6'b101010, 32'hffffffff, 6'b101010);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    res("rst", 0, 0, 0, 0, 0, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    run_scan("t1", cyc);
    chk("t1_latency", cyc, 226);
    res("t1", 16, 32, 1, 16, 32, 1);
    @(posedge clk);
    #1 chk("t1_done_pulse", bus.o_done, 0);
    res("t1_hold", 16, 32, 1, 16, 32, 1);
    set_pat(32'h001ffc00, 6'b101010, 32'h00000007, 6'b110100);
    run_scan("t2", cyc);
    res("t2", 15, 11, 1, 0, 3, 0);
    set_pat(32'h00f00078, 6'b101010, 32'h00f00038, 6'b010101);
    run_scan("t3", cyc);
    res("t3", 5, 4, 1, 22, 4, 1);
    set_pat(32'h00000000, 6'b101010, 32'hffffffff, 6'b000000);
    run_scan("t4", cyc);
    res("t4", 0, 0, 0, 0, 0, 0);
    set_pat(32'h000000ff, 6'b110010, 32'hfe000000, 6'b011100);
    run_scan("t5", cyc);
    res("t5", 4, 8, 1, 28, 7, 1);
    @(negedge clk) bus.i_start = 1'b1;
    @(negedge clk) bus.i_start = 1'b0;
    repeat (5) @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk) bus.i_start = 1'b0;
    k = 0;
    while (bus.o_delay_val[4:0] != 5'd12 && k < 500) begin
      @(posedge clk);
      #1 k++;
    end
    chk("t6_tap12", k < 500, 1);
    chk("t6_busy_mid", bus.o_busy, 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 res("t6_rst", 0, 0, 0, 0, 0, 0);
    chk("t6_rst_busy", bus.o_busy, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("t6_idle_busy", bus.o_busy, 0);
    chk("t6_idle_done", bus.o_done, 0);
    run_scan("t6", cyc);
    chk("t6_latency", cyc, 226);
    res("t6", 4, 8, 1, 28, 7, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
